// File: rtl/audioport_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audioport_pkg
// Desc     : Shared audioport constants and the I2S receiver state type.
// Revision : 1.0  initial release
// ============================================================================
package audioport_pkg;

  localparam int AUDIO_BW   = 24;
  localparam int I2S_SLOT_W = 32;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_SYNC = 2'd1,
    RX_RUN  = 2'd2
  } i2s_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_unit_if
// Desc     : Stereo sample-pair stream (valid/ready) out of the I2S receiver.
// Revision : 1.0  initial release
// ============================================================================
interface i2s_rx_unit_if #(
  parameter int DATA_W = audioport_pkg::AUDIO_BW
);
  logic [DATA_W-1:0] rx_left_out;
  logic [DATA_W-1:0] rx_right_out;
  logic              rx_valid_out;
  logic              rx_ready_in;

  modport master (
    output rx_left_out,
    output rx_right_out,
    output rx_valid_out,
    input  rx_ready_in
  );

  modport slave (
    input  rx_left_out,
    input  rx_right_out,
    input  rx_valid_out,
    output rx_ready_in
  );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_unit_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_sync
// Desc     : Two-flop synchronizer, asynchronous reset to 0.
// Revision : 1.0  initial release
// ============================================================================
module i2s_rx_sync (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_d,
  output logic o_q
);
  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/i2s_rx_unit.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_unit
// Desc     : I2S slave receiver, sck/ws/sd oversampled in clk, stereo pairs out
//            on a valid/ready port. Define I2S_RX_FRAMECHK_EN for slot checking.
// Revision : 1.0  initial release
// ============================================================================
module i2s_rx_unit
  import audioport_pkg::*;
#(
  parameter int DATA_W = AUDIO_BW,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  enable_in,
  input  wire                  sck_in,
  input  wire                  ws_in,
  input  wire                  sdi_in,
  i2s_rx_unit_if.master        rx_if,
  output logic                 overrun_out,
  output logic                 frame_err_out,
  input  wire                  clr_in
);

  localparam logic [DATA_W-1:0] c_msb_bit = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [5:0]        c_cnt_max = 6'd63;
`ifdef I2S_RX_FRAMECHK_EN
  localparam bit c_framechk = 1'b1;
`else
  localparam bit c_framechk = 1'b0;
`endif

  logic w_sck_s, w_ws_s, w_sd_s;

  i2s_rx_sync u_sync_sck (.clk(clk), .rst_n(rst_n), .i_d(sck_in), .o_q(w_sck_s));
  i2s_rx_sync u_sync_ws  (.clk(clk), .rst_n(rst_n), .i_d(ws_in),  .o_q(w_ws_s));
  i2s_rx_sync u_sync_sd  (.clk(clk), .rst_n(rst_n), .i_d(sdi_in), .o_q(w_sd_s));

  i2s_rx_state_t     r_state;
  logic              r_sck_prev, r_strobe, r_ws_d, r_sd_d, r_ws_prev;
  logic [DATA_W-1:0] r_shift, r_left_hold, r_left_out, r_right_out;
  logic [5:0]        r_bitcnt;
  logic              r_left_vld, r_valid, r_overrun, r_frame_err;

  logic              w_ws_chg, w_run_chg, w_frame_bad, w_right_done, w_load, w_drop;
  logic [5:0]        w_slot_len;
  logic [DATA_W-1:0] w_word;

  // Current strobe's bit is merged in so the LSB carried by the ws-change strobe lands in the word.
  assign w_word       = r_shift | (r_sd_d ? (c_msb_bit >> r_bitcnt) : '0);
  assign w_slot_len   = (r_bitcnt == c_cnt_max) ? c_cnt_max : r_bitcnt + 6'd1;
  assign w_ws_chg     = r_strobe & (r_ws_d != r_ws_prev);
  assign w_run_chg    = enable_in & (r_state == RX_RUN) & w_ws_chg;
  assign w_frame_bad  = c_framechk & w_run_chg & (w_slot_len != 6'(SLOT_W));
  assign w_right_done = w_run_chg & ~r_ws_d & r_left_vld & ~w_frame_bad;
  assign w_load       = w_right_done & (~r_valid | rx_if.rx_ready_in);
  assign w_drop       = w_right_done & r_valid & ~rx_if.rx_ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RX_IDLE;
      r_sck_prev  <= 1'b0;
      r_strobe    <= 1'b0;
      r_ws_d      <= 1'b0;
      r_sd_d      <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_left_hold <= '0;
      r_left_vld  <= 1'b0;
      r_left_out  <= '0;
      r_right_out <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_prev <= w_sck_s;
      r_strobe   <= w_sck_s & ~r_sck_prev;
      r_ws_d     <= w_ws_s;
      r_sd_d     <= w_sd_s;
      // ws history tracks in every state so entering SYNC never sees a stale change.
      if (r_strobe) r_ws_prev <= r_ws_d;

      if (w_load) begin
        r_left_out  <= r_left_hold;
        r_right_out <= w_word;
        r_valid     <= 1'b1;
      end else if (r_valid && rx_if.rx_ready_in) begin
        r_valid <= 1'b0;
      end
      r_overrun   <= (r_overrun & ~clr_in) | w_drop;
      r_frame_err <= (r_frame_err & ~clr_in) | w_frame_bad;

      if (!enable_in) begin
        r_state    <= RX_IDLE;
        r_shift    <= '0;
        r_bitcnt   <= '0;
        r_left_vld <= 1'b0;
      end else begin
        case (r_state)
          RX_IDLE: r_state <= RX_SYNC;
          RX_SYNC, RX_RUN: begin
            if (r_strobe) begin
              if (w_ws_chg) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
                if (r_state == RX_SYNC) begin
                  if (r_ws_d) begin
                    r_state    <= RX_RUN;
                    r_left_vld <= 1'b0;
                  end
                end else if (w_frame_bad) begin
                  r_state    <= RX_SYNC;
                  r_left_vld <= 1'b0;
                end else if (r_ws_d) begin
                  r_left_hold <= w_word;
                  r_left_vld  <= 1'b1;
                end else begin
                  r_left_vld <= 1'b0;
                end
              end else begin
                r_shift <= w_word;
                if (r_bitcnt != c_cnt_max) r_bitcnt <= r_bitcnt + 6'd1;
              end
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_if.rx_left_out  = r_left_out;
  assign rx_if.rx_right_out = r_right_out;
  assign rx_if.rx_valid_out = r_valid;
  assign overrun_out        = r_overrun;
  assign frame_err_out      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_unit
// Desc     : Self-checking bench for i2s_rx_unit, clk = 8x sck, random frames
//            checked against a slot-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_rx_unit;
  import audioport_pkg::*;

`ifdef I2S_RX_FRAMECHK_EN
  localparam bit FCHK      = 1'b1;
  localparam int SHORT_LEN = 30;
`else
  localparam bit FCHK      = 1'b0;
  localparam int SHORT_LEN = 16;
`endif

  logic clk = 1'b0, rst_n = 1'b1, enable_in = 1'b0, clr_in = 1'b0;
  logic sck_in = 1'b0, ws_in = 1'b0, sdi_in = 1'b0;
  logic overrun_out, frame_err_out;

  i2s_rx_unit_if rx_if ();

  i2s_rx_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_in     (enable_in),
    .sck_in        (sck_in),
    .ws_in         (ws_in),
    .sdi_in        (sdi_in),
    .rx_if         (rx_if),
    .overrun_out   (overrun_out),
    .frame_err_out (frame_err_out),
    .clr_in        (clr_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0, n_fail = 0;
  int          rise_cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] last_pair = '0;
  bit          m_sync = 0, m_leftv = 0, exp_ovr = 0, exp_ferr = 0;
  logic [23:0] m_left = '0;
  logic        pv = 1'b0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected sample: first 24 slot bits MSB first, missing LSBs zero.
  function automatic logic [23:0] slot_sample(input logic [31:0] w32, input int len);
    logic [23:0] mask;
    mask = 24'hFFFFFF;
    if (len < 24) mask = ~(mask >> len);
    return w32[31:8] & mask;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_leftv = 0; exp_ovr = 0; exp_ferr = 0;
    exp_q.delete();
  endtask

  task automatic model_disable();
    m_sync = 0; m_leftv = 0;
  endtask

  // w = ws level of the slot that just ended (0 = left).
  task automatic model_slot_done(input logic w, input int len, input logic [23:0] smp);
    if (!enable_in) return;
    if (!m_sync) begin
      if (w == 1'b0) begin m_sync = 1; m_leftv = 0; end
    end else if (FCHK && len != I2S_SLOT_W) begin
      exp_ferr = 1; m_sync = 0; m_leftv = 0;
    end else if (w == 1'b0) begin
      m_left = smp; m_leftv = 1;
    end else begin
      if (m_leftv) begin
        if (exp_q.size() == 0 || rx_if.rx_ready_in) exp_q.push_back({m_left, smp});
        else exp_ovr = 1;
      end
      m_leftv = 0;
    end
  endtask

  task automatic send_bit(input logic b, input logic w);
    sck_in = 1'b0; sdi_in = b; ws_in = w;
    repeat (4) @(negedge clk);
    sck_in = 1'b1; rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  // ws flips on the slot's last bit (Philips framing).
  task automatic send_slot(input logic [31:0] w32, input int len, input logic w, input int drop_at);
    for (int i = 0; i < len; i++) begin
      if (i == drop_at) begin enable_in = 1'b0; model_disable(); end
      send_bit(w32[31-i], (i == len - 1) ? ~w : w);
    end
    model_slot_done(w, len, slot_sample(w32, len));
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int llen, input int drop_at);
    send_slot({l, 8'($urandom)}, llen, 1'b0, -1);
    send_slot({r, 8'($urandom)}, 32, 1'b1, drop_at);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clr_pulse();
    clr_in = 1'b1;
    @(negedge clk);
    clr_in = 1'b0;
    exp_ovr = 0; exp_ferr = 0;
    #1;
  endtask

  // Output monitor: latency of each new pair and every transfer against the model queue.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rx_if.rx_valid_out && !pv) begin
        check("valid_latency", 48'(cyc - rise_cyc), 48'd4);
        check("valid_expected", 48'(exp_q.size() != 0), 48'd1);
      end
      if (rx_if.rx_valid_out && rx_if.rx_ready_in && exp_q.size() != 0) begin
        last_pair = {rx_if.rx_left_out, rx_if.rx_right_out};
        check("pair", last_pair, exp_q.pop_front());
      end
      pv = rx_if.rx_valid_out;
    end
  end

  initial begin
    rx_if.rx_ready_in = 1'b1;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_valid", 48'(rx_if.rx_valid_out), 48'd0);
    check("rst_left", 48'(rx_if.rx_left_out), 48'd0);
    check("rst_right", 48'(rx_if.rx_right_out), 48'd0);
    check("rst_overrun", 48'(overrun_out), 48'd0);
    check("rst_frame_err", 48'(frame_err_out), 48'd0);
    @(negedge clk);
    rst_n = 1'b1; enable_in = 1'b1;
    model_reset();

    // First frame only synchronises; second one is the known pair.
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    settle();
    check("no_pair_after_sync", 48'(rx_if.rx_valid_out), 48'd0);
    send_frame(24'h123456, 24'hABCDEF, 32, -1);
    settle();
    check("known_pair", last_pair, {24'h123456, 24'hABCDEF});

    // Backpressure across two pairs.
    rx_if.rx_ready_in = 1'b0;
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    settle();
    check("overrun_set", 48'(overrun_out), 48'(exp_ovr));
    check("held_count", 48'(exp_q.size()), 48'd1);
    if (exp_q.size() != 0)
      check("held_pair", {rx_if.rx_left_out, rx_if.rx_right_out}, exp_q[0]);
    clr_pulse();
    check("overrun_clr", 48'(overrun_out), 48'(exp_ovr));
    rx_if.rx_ready_in = 1'b1;
    repeat (3) settle();
    check("drained_valid", 48'(rx_if.rx_valid_out), 48'(exp_q.size() != 0));

    // Reset in the middle of a left slot with a pending pair and overrun.
    rx_if.rx_ready_in = 1'b0;
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 48'(rx_if.rx_valid_out), 48'd0);
    check("midrst_pair", {rx_if.rx_left_out, rx_if.rx_right_out}, 48'd0);
    check("midrst_overrun", 48'(overrun_out), 48'd0);
    sck_in = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1; rx_if.rx_ready_in = 1'b1;
    send_frame(24'($urandom), 24'($urandom), 32, -1);
    settle();
    check("no_pair_after_rst", 48'(rx_if.rx_valid_out), 48'd0);
    send_frame(24'($urandom), 24'($urandom), 32, -1);

    // Streaming, then enable dropped mid right slot.
    for (int k = 0; k < 16; k++) send_frame(24'($urandom), 24'($urandom), 32, -1);
    send_frame(24'($urandom), 24'($urandom), 32, 12);
    repeat (4) settle();
    check("no_partial_pair", 48'(rx_if.rx_valid_out), 48'd0);
    enable_in = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(24'($urandom), 24'($urandom), 32, -1);

    // Short left slot.
    send_frame(24'hBEEF5A, 24'($urandom), SHORT_LEN, -1);
    settle();
    check("frame_err_flag", 48'(frame_err_out), 48'(exp_ferr));
`ifdef I2S_RX_FRAMECHK_EN
    check("frame_err_set", 48'(frame_err_out), 48'd1);
`else
    check("short_slot_left", 48'(last_pair[47:24]), 48'h0000_00BEEF00);
`endif
    clr_pulse();
    check("frame_err_clr", 48'(frame_err_out), 48'(exp_ferr));
    for (int k = 0; k < 3; k++) send_frame(24'($urandom), 24'($urandom), 32, -1);

    repeat (20) settle();
    check("all_pairs_seen", 48'(exp_q.size()), 48'd0);
    check("final_overrun", 48'(overrun_out), 48'(exp_ovr));
    check("final_frame_err", 48'(frame_err_out), 48'(exp_ferr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
